// File: rtl/fft_seq.sv
// FFT frame sequencer: counts FIR samples into 16-sample frames, delays frame_go to a capture strobe, and serves the 16 bins downstream.
// Optional FFT_SEQ_DROP_CNT_EN adds an 8-bit saturating dropped-frame counter (drop_cnt).
module fft_seq #(
  parameter int LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fir_valid,
  input  logic       sclr,
  input  logic       ovf_clr,
  input  logic       rd_ready,
  output logic       ld_en,
  output logic       frame_go,
  output logic       cap_we,
  output logic       rd_valid,
  output logic [3:0] rd_idx,
  output logic       rd_last,
  output logic       busy,
  output logic       ovf
`ifdef FFT_SEQ_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           smp_cnt;
  logic [LATENCY-1:0]   go_sr;
  logic [3:0]           rd_idx_nxt;
  logic                 cap_evt;
  logic                 hs;
  logic                 hs_last;
  logic                 drop;

  assign ld_en    = fir_valid & ~sclr;
  assign cap_evt  = go_sr[LATENCY-1];
  assign rd_valid = (state == READ);
  assign busy     = (state == READ);
  assign rd_last  = rd_valid & (rd_idx == 4'd15);
  assign hs       = rd_valid & rd_ready;
  assign hs_last  = hs & (rd_idx == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_cnt  <= 4'd0;
      frame_go <= 1'b0;
    end else if (sclr) begin
      smp_cnt  <= 4'd0;
      frame_go <= 1'b0;
    end else begin
      frame_go <= fir_valid & (smp_cnt == 4'd15);
      if (fir_valid)
        smp_cnt <= smp_cnt + 4'd1;
    end
  end

  // Frames are >=16 cycles apart, so at most one pulse is ever in this line.
  generate
    if (LATENCY == 1) begin : g_sr1
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       go_sr <= '0;
        else if (sclr) go_sr <= '0;
        else           go_sr <= frame_go;
      end
    end else begin : g_srn
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       go_sr <= '0;
        else if (sclr) go_sr <= '0;
        else           go_sr <= {go_sr[LATENCY-2:0], frame_go};
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rd_idx <= 4'd0;
    end else begin
      state  <= state_nxt;
      rd_idx <= rd_idx_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rd_idx_nxt = rd_idx;
    cap_we     = 1'b0;
    drop       = 1'b0;
    if (sclr) begin
      state_nxt  = IDLE;
      rd_idx_nxt = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cap_evt) begin
            cap_we     = 1'b1;
            state_nxt  = READ;
            rd_idx_nxt = 4'd0;
          end
        end
        READ: begin
          if (hs_last) begin
            rd_idx_nxt = 4'd0;
            // A capture landing on the final handshake starts the next readout seamlessly.
            if (cap_evt) begin
              cap_we    = 1'b1;
              state_nxt = READ;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            if (hs)
              rd_idx_nxt = rd_idx + 4'd1;
            if (cap_evt)
              drop = 1'b1;
          end
        end
        default: begin
          state_nxt  = IDLE;
          rd_idx_nxt = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

`ifdef FFT_SEQ_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else if (drop) begin
      if (drop_cnt != 8'hff)
        drop_cnt <= drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      drop_cnt <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_fft_seq.sv
// Self-checking bench for fft_seq: directed scenarios plus random traffic against a frame/queue-level reference model.
module tb_fft_seq;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       fir_valid;
  logic       sclr;
  logic       ovf_clr;
  logic       rd_ready;
  logic       ld_en;
  logic       frame_go;
  logic       cap_we;
  logic       rd_valid;
  logic [3:0] rd_idx;
  logic       rd_last;
  logic       busy;
  logic       ovf;
`ifdef FFT_SEQ_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  fft_seq #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .sclr(sclr), .ovf_clr(ovf_clr),
    .rd_ready(rd_ready), .ld_en(ld_en), .frame_go(frame_go), .cap_we(cap_we),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_last(rd_last), .busy(busy), .ovf(ovf)
`ifdef FFT_SEQ_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: frame-level view with a queue of scheduled capture cycles.
  int m_cnt, m_idx, m_drops, cyc;
  bit m_fg, m_rd, m_ovf;
  int cap_q[$];

  // Per-scenario observations of DUT events.
  int t_fg, t_cap, t_last, n_fg, n_cap, n_hs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_drops = 0; m_fg = 0; m_rd = 0; m_ovf = 0;
    cap_q.delete();
  endtask

  task automatic clear_obs();
    t_fg = -1; t_cap = -1; t_last = -1; n_fg = 0; n_cap = 0; n_hs = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ld_en"}, ld_en, 0);
    check({tag, "_frame_go"}, frame_go, 0);
    check({tag, "_cap_we"}, cap_we, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_idx"}, rd_idx, 0);
    check({tag, "_rd_last"}, rd_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ovf"}, ovf, 0);
`ifdef FFT_SEQ_DROP_CNT_EN
    check({tag, "_drop_cnt"}, drop_cnt, 0);
`endif
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic tick();
    bit cap_evt, hs_last, e_cap, drop, new_fg;
    #4;
    cap_evt = (cap_q.size() > 0) && (cap_q[0] == cyc);
    hs_last = m_rd && rd_ready && (m_idx == 15);
    e_cap   = cap_evt && !sclr && (!m_rd || hs_last);
    drop    = cap_evt && !sclr && m_rd && !hs_last;
    check("ld_en", ld_en, fir_valid && !sclr);
    check("frame_go", frame_go, m_fg);
    check("cap_we", cap_we, e_cap);
    check("rd_valid", rd_valid, m_rd);
    check("rd_idx", rd_idx, m_idx);
    check("rd_last", rd_last, m_rd && m_idx == 15);
    check("busy", busy, m_rd);
    check("ovf", ovf, m_ovf);
`ifdef FFT_SEQ_DROP_CNT_EN
    check("drop_cnt", drop_cnt, m_drops);
`endif
    if (frame_go === 1'b1) begin n_fg++; if (t_fg < 0) t_fg = cyc; end
    if (cap_we === 1'b1) begin n_cap++; if (t_cap < 0) t_cap = cyc; end
    if (rd_valid === 1'b1 && rd_ready) n_hs++;
    if (rd_last === 1'b1 && rd_ready && t_last < 0) t_last = cyc;
    @(posedge clk);
    if (cap_evt) void'(cap_q.pop_front());
    if (sclr) begin
      m_cnt = 0; m_fg = 0; m_rd = 0; m_idx = 0;
      cap_q.delete();
    end else begin
      new_fg = fir_valid && (m_cnt == 15);
      if (new_fg) cap_q.push_back(cyc + 1 + LAT);
      m_fg = new_fg;
      if (fir_valid) m_cnt = (m_cnt + 1) % 16;
      if (e_cap) begin
        m_rd = 1; m_idx = 0;
      end else if (m_rd && rd_ready) begin
        if (m_idx == 15) begin m_rd = 0; m_idx = 0; end
        else m_idx++;
      end
    end
    if (drop) begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end else if (ovf_clr) begin
      m_ovf = 0; m_drops = 0;
    end
    cyc++;
    #1;
  endtask

  initial begin
    int base;
    bit found;
    rst = 1; fir_valid = 0; sclr = 0; ovf_clr = 0; rd_ready = 0;
    model_reset(); clear_obs(); cyc = 0;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Fill: 16 samples from cycle 0, full-rate readout.
    clear_obs(); base = cyc; rd_ready = 1;
    for (int i = 0; i < 16; i++) begin fir_valid = 1; tick(); end
    fir_valid = 0;
    repeat (25) tick();
    check("fill_frame_go_cyc", t_fg - base, 16);
    check("fill_cap_we_cyc", t_cap - base, 16 + LAT);
    check("fill_rd_last_cyc", t_last - base, 16 + LAT + 16);
    check("fill_busy_after", busy, 0);

    // Backpressure: rd_ready alternates.
    clear_obs();
    for (int i = 0; i < 70; i++) begin
      fir_valid = (i < 16); rd_ready = i[0];
      tick();
    end
    check("bp_handshakes", n_hs, 16);
    check("bp_caps", n_cap, 1);

    // Overflow: a few bins read, then stall through the second capture.
    clear_obs();
    for (int i = 0; i < 85; i++) begin
      fir_valid = (i < 32);
      rd_ready = (i >= 21 && i < 27) || (i >= 45);
      if (i == 44) begin
        check("ovf_sticky", ovf, 1);
        check("ovf_stalled_idx", rd_idx, 6);
`ifdef FFT_SEQ_DROP_CNT_EN
        check("ovf_drop_cnt", drop_cnt, 1);
`endif
      end
      tick();
    end
    check("ovf_caps", n_cap, 1);
    check("ovf_handshakes", n_hs, 16);
    ovf_clr = 1; tick(); ovf_clr = 0; tick();
    check("ovf_cleared", ovf, 0);

    // Back-to-back: continuous samples, full-rate readout.
    clear_obs(); rd_ready = 1;
    for (int i = 0; i < 110; i++) begin
      fir_valid = (i < 64);
      tick();
    end
    check("b2b_caps", n_cap, 4);
    check("b2b_handshakes", n_hs, 64);
    check("b2b_no_ovf", ovf, 0);

    // Mid-frame sclr after 7 samples.
    clear_obs();
    for (int i = 0; i < 7; i++) begin fir_valid = 1; tick(); end
    fir_valid = 0; sclr = 1; base = cyc; tick(); sclr = 0;
    for (int i = 0; i < 16; i++) begin fir_valid = 1; tick(); end
    fir_valid = 0;
    repeat (40) tick();
    check("sclr_single_go", n_fg, 1);
    check("sclr_go_cyc", t_fg - base, 17);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      fir_valid = ($urandom % 4) != 0;
      rd_ready  = ($urandom % 3) != 0;
      sclr      = ($urandom % 200) == 0;
      ovf_clr   = ($urandom % 60) == 0;
      tick();
    end
    fir_valid = 0; rd_ready = 0; ovf_clr = 0;
    sclr = 1; tick(); sclr = 0;

    // Reset while reading bin 9 with the next frame in flight.
    found = 0; rd_ready = 1;
    for (int i = 0; i < 200 && !found; i++) begin
      fir_valid = 1;
      if (m_rd && m_idx == 9) found = 1;
      else tick();
    end
    check("rst_reached_idx9", found, 1);
    fir_valid = 0; rst = 1;
    #1;
    check_all_zero("rst_read");
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    clear_obs();
    repeat (40) tick();
    check("rst_no_cap", n_cap, 0);
    for (int i = 0; i < 16; i++) begin fir_valid = 1; tick(); end
    fir_valid = 0;
    repeat (40) tick();
    check("rst_new_frame_cap", n_cap, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
